// File: rtl/and_or_latch_pkg.sv
// and_or_latch_pkg: shared state encoding, operand layout and reference function for the latch scheduler
package and_or_latch_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, OPEN, CLOSE, RESP} state_t;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
    } operand_t;

    function automatic logic aol_eval(input operand_t o);
        return (o.a & o.b) | (o.c & o.d);
    endfunction

endpackage

// File: rtl/and_or_latch.sv
// and_or_latch: f = (a&b)|(c&d), transparent while en=1, holds while en=0
module and_or_latch (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic en,
    output logic f
);

    // level-sensitive storage: follow the function while open, hold otherwise
    always_latch
        if (en) f <= (a & b) | (c & d);

endmodule

// File: rtl/and_or_latch_sched_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, wrapping
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IW = $clog2(N_REQ);

    logic          found;
    logic [IW-1:0] j;

    // scan upward from ptr with wraparound; first valid requester wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = IW'((int'(ptr) + k) % N_REQ);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/and_or_latch_sched.sv
// and_or_latch_sched: round-robin scheduler for one shared and_or_latch; AND_OR_LATCH_SCHED_CHECK_EN adds chk_err
module and_or_latch_sched
    import and_or_latch_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [4*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     rsp_f,
    input  logic                     rsp_ready,
    output logic                     lat_a,
    output logic                     lat_b,
    output logic                     lat_c,
    output logic                     lat_d,
    output logic                     lat_en,
    input  logic                     lat_f,
    output logic                     busy
`ifdef AND_OR_LATCH_SCHED_CHECK_EN
    ,
    output logic                     chk_err
`endif
);

    localparam int MAXC = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int IW   = $clog2(N_REQ);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [IW-1:0] ptr, id, gnt_idx;
    logic [N_REQ-1:0] gnt;
    operand_t      op;
    logic          f_q;
    logic          accept;
    logic          drive;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign accept = (state == IDLE) && (|req_valid);

    // sequence setup, enable window, hold-margin close and response handshake
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE:  if (accept) begin
                state_nx = SETUP;
                cnt_nx   = '0;
            end
            SETUP: if (cnt == CW'(SETUP_CYC - 1)) begin
                state_nx = OPEN;
                cnt_nx   = '0;
            end else cnt_nx = cnt + 1'b1;
            OPEN:  if (cnt == CW'(EN_CYC - 1)) begin
                state_nx = CLOSE;
                cnt_nx   = '0;
            end else cnt_nx = cnt + 1'b1;
            CLOSE: state_nx = RESP;
            RESP:  state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // outputs decoded from state; operands only reach the latch while a request is in flight
    always_comb begin
        drive     = (state == SETUP) || (state == OPEN) || (state == CLOSE);
        req_ready = (state == IDLE && !rst) ? gnt : '0;
        {lat_a, lat_b, lat_c, lat_d} = drive ? 4'(op) : 4'b0;
        lat_en    = (state == OPEN);
        rsp_valid = (state == RESP);
        rsp_id    = (state == RESP) ? id : '0;
        rsp_f     = (state == RESP) && f_q;
        busy      = (state != IDLE);
    end

    // state, pointer and capture registers; f is sampled as CLOSE ends
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            id    <= '0;
            op    <= '0;
            f_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                id  <= gnt_idx;
                op  <= operand_t'(req_data[{gnt_idx, 2'b00} +: 4]);
                ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (state == CLOSE) f_q <= lat_f;
        end
    end

`ifdef AND_OR_LATCH_SCHED_CHECK_EN
    // sticky flag when the latch disagrees with the reference function at close
    always_ff @(posedge clk) begin
        if (rst) chk_err <= 1'b0;
        else if (state == CLOSE && lat_f != aol_eval(op)) chk_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_and_or_latch_sched.sv
// tb_and_or_latch_sched: directed scoreboard bench for and_or_latch_sched driving a real and_or_latch
module tb_and_or_latch_sched;
    import and_or_latch_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [1:0] id;
        logic       f;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid, req_ready;
    logic [4*N-1:0] req_data;
    logic         rsp_valid, rsp_f, rsp_ready;
    logic [1:0]   rsp_id;
    logic         lat_a, lat_b, lat_c, lat_d, lat_en, lat_q, lat_f, busy;
    logic         inj = 1'b0;
`ifdef AND_OR_LATCH_SCHED_CHECK_EN
    logic         chk_err;
`endif

    int   n_chk = 0, n_err = 0, cyc = 0, acc_cyc = 0, en_cnt = 0, n_rsp = 0;
    exp_t sb[$];
    int   gq[$];
    logic prev_rv = 1'b0, prev_en = 1'b0;
    logic [3:0] prev_op = '0;

    always #5 clk = ~clk;

    and_or_latch u_lat (
        .a(lat_a), .b(lat_b), .c(lat_c), .d(lat_d), .en(lat_en), .f(lat_q)
    );

    assign lat_f = lat_q ^ inj;

    and_or_latch_sched #(.N_REQ(N), .SETUP_CYC(1), .EN_CYC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_f     (rsp_f),
        .rsp_ready (rsp_ready),
        .lat_a     (lat_a),
        .lat_b     (lat_b),
        .lat_c     (lat_c),
        .lat_d     (lat_d),
        .lat_en    (lat_en),
        .lat_f     (lat_f),
        .busy      (busy)
`ifdef AND_OR_LATCH_SCHED_CHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (rst) begin
            sb.delete();
            en_cnt = 0;
        end else begin
            if (lat_en) en_cnt++;
            if (prev_en) chk("op_hold", 32'({lat_a, lat_b, lat_c, lat_d}), 32'(prev_op));
            if (lat_en) chk("en_busy", 32'(busy), 1);
            if (|req_ready) begin
                chk("onehot", 32'($onehot(req_ready)), 1);
                chk("ready_sub", 32'(req_ready & ~req_valid), 0);
                for (int k = 0; k < N; k++)
                    if (req_ready[k]) begin
                        e.id = 2'(k);
                        e.f  = aol_eval(operand_t'(req_data[4*k +: 4])) ^ inj;
                        sb.push_back(e);
                        gq.push_back(k);
                        acc_cyc = cyc;
                    end
            end
            if (rsp_valid && !prev_rv) begin
                chk("latency", 32'(cyc - acc_cyc), 5);
                chk("en_cycles", 32'(en_cnt), 2);
                en_cnt = 0;
            end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
                else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_f", 32'(rsp_f), 32'(e.f));
                end
            end
        end
        prev_rv = rsp_valid && !rst;
        prev_en = lat_en && !rst;
        prev_op = {lat_a, lat_b, lat_c, lat_d};
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy || sb.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        chk("idle_busy", 32'(busy), 0);
        chk("idle_sb_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        int n, v, n_rsp0;
        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        // reset with every requester valid: everything quiet
        repeat (3) begin
            chk("rst_outs", 32'({req_ready, rsp_valid, rsp_id, rsp_f, lat_a, lat_b, lat_c, lat_d, lat_en, busy}), 0);
            tick();
        end
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        wait_idle(20);
        // single requester 2: 1100 -> f=1, then 1010 -> f=0
        req_valid = 4'b0100;
        req_data  = 16'h0C00;
        tick();
        req_valid = '0;
        wait_idle(20);
        req_valid = 4'b0100;
        req_data  = 16'h0A00;
        tick();
        req_valid = '0;
        wait_idle(20);
        // requester 3 moves the pointer back to 0
        req_valid = 4'b1000;
        req_data  = 16'h3000;
        tick();
        req_valid = '0;
        wait_idle(20);
        // all valid: round-robin order while sweeping every operand value
        gq.delete();
        v = 0;
        req_valid = '1;
        req_data  = {4{4'(v)}};
        n = 0;
        while (gq.size() < 16 && n < 200) begin
            tick();
            n++;
            if (gq.size() > v) begin
                v++;
                req_data = {4{4'(v)}};
            end
        end
        req_valid = '0;
        wait_idle(20);
        chk("rr_count", 32'(gq.size()), 16);
        for (int i = 0; i < gq.size(); i++) chk("rr_order", 32'(gq[i]), 32'(i % 4));
        // response back-pressure: result held, no grants, latch closed
        req_valid = 4'b0010;
        req_data  = 16'h00F0;
        rsp_ready = 1'b0;
        tick();
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_rsp_valid", 32'(rsp_valid), 1);
        req_valid = '1;
        repeat (10) begin
            tick();
            chk("bp_hold", 32'({rsp_valid, rsp_id, rsp_f, req_ready, lat_en}), 32'({1'b1, 2'd1, 1'b1, 4'b0, 1'b0}));
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        tick();
        wait_idle(20);
        // reset while the latch is open drops the request
        req_valid = 4'b0001;
        req_data  = 16'h000F;
        tick();
        req_valid = '0;
        n = 0;
        while (!lat_en && n < 10) begin
            tick();
            n++;
        end
        chk("mid_open", 32'(lat_en), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst", 32'({busy, lat_en, rsp_valid}), 0);
        rst = 1'b0;
        n_rsp0 = n_rsp;
        repeat (10) tick();
        chk("mid_no_rsp", 32'(n_rsp - n_rsp0), 0);
        chk("mid_idle", 32'(busy), 0);
`ifdef AND_OR_LATCH_SCHED_CHECK_EN
        // corrupted latch output trips the sticky checker
        chk("chk_err_clear", 32'(chk_err), 0);
        inj       = 1'b1;
        req_valid = 4'b0001;
        req_data  = 16'h000F;
        tick();
        req_valid = '0;
        wait_idle(20);
        inj = 1'b0;
        chk("chk_err_set", 32'(chk_err), 1);
        repeat (3) tick();
        chk("chk_err_sticky", 32'(chk_err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("chk_err_rst", 32'(chk_err), 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
